// File: rtl/max_unpool2d.sv
// Streaming 2D max-unpooling: scatters each pooled value to its argmax slot in a
// KERNEL_HEIGHT x KERNEL_WIDTH window, zero-fills the rest, emits in raster order.
module max_unpool2d #(
    parameter int DATA_IN_0_PRECISION_0  = 8,
    parameter int DATA_IN_0_PRECISION_1  = 3,
    parameter int DATA_IN_0_WIDTH        = 2,
    parameter int DATA_IN_0_HEIGHT       = 2,
    parameter int KERNEL_WIDTH           = 2,
    parameter int KERNEL_HEIGHT          = 2,
    parameter int DATA_OUT_0_PRECISION_0 = 8,
    parameter int DATA_OUT_0_PRECISION_1 = 3,
    parameter int DATA_OUT_0_WIDTH       = 4,
    parameter int DATA_OUT_0_HEIGHT      = 4,
    localparam int INDEX_WIDTH = (KERNEL_WIDTH * KERNEL_HEIGHT > 1) ?
                                 $clog2(KERNEL_WIDTH * KERNEL_HEIGHT) : 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [DATA_IN_0_PRECISION_0-1:0]  data_in_0,
    input  logic [INDEX_WIDTH-1:0]            index_in_0,
    input  logic                              data_in_0_valid,
    output logic                              data_in_0_ready,
    output logic [DATA_OUT_0_PRECISION_0-1:0] data_out_0,
    output logic                              data_out_0_last,
    output logic                              data_out_0_valid,
    input  logic                              data_out_0_ready
);

    localparam int COL_W  = (DATA_IN_0_WIDTH  > 1) ? $clog2(DATA_IN_0_WIDTH)  : 1;
    localparam int ROW_W  = (DATA_IN_0_HEIGHT > 1) ? $clog2(DATA_IN_0_HEIGHT) : 1;
    localparam int M_W    = (KERNEL_HEIGHT    > 1) ? $clog2(KERNEL_HEIGHT)    : 1;
    localparam int N_W    = (KERNEL_WIDTH     > 1) ? $clog2(KERNEL_WIDTH)     : 1;

    localparam logic [COL_W-1:0] COL_MAX  = COL_W'(DATA_IN_0_WIDTH - 1);
    localparam logic [ROW_W-1:0] PROW_MAX = ROW_W'(DATA_IN_0_HEIGHT - 1);
    localparam logic [M_W-1:0]   M_MAX    = M_W'(KERNEL_HEIGHT - 1);
    localparam logic [N_W-1:0]   N_MAX    = N_W'(KERNEL_WIDTH - 1);

    generate
        if (DATA_OUT_0_PRECISION_0 != DATA_IN_0_PRECISION_0 ||
            DATA_OUT_0_PRECISION_1 != DATA_IN_0_PRECISION_1 ||
            DATA_OUT_0_WIDTH  != DATA_IN_0_WIDTH  * KERNEL_WIDTH ||
            DATA_OUT_0_HEIGHT != DATA_IN_0_HEIGHT * KERNEL_HEIGHT) begin : g_bad_cfg
            $error("max_unpool2d: inconsistent output parameters");
        end
    endgenerate

    typedef enum logic {S_LOAD, S_EMIT} state_t;

    typedef struct packed {
        logic [DATA_IN_0_PRECISION_0-1:0] value;
        logic [INDEX_WIDTH-1:0]           index;
    } entry_t;

    entry_t line_q [DATA_IN_0_WIDTH];

    state_t                            state_q, state_d;
    logic [COL_W-1:0]                  load_col_q, load_col_d;
    logic [COL_W-1:0]                  j_q, j_d;
    logic [M_W-1:0]                    m_q, m_d;
    logic [N_W-1:0]                    n_q, n_d;
    logic [ROW_W-1:0]                  prow_q, prow_d;
    logic [DATA_OUT_0_PRECISION_0-1:0] out_q, out_d;
    logic                              last_q, last_d;
    logic                              valid_q, valid_d;
    logic                              accept;
    logic                              match;
    logic [31:0]                       target;

    assign data_in_0_ready  = (state_q == S_LOAD);
    assign data_out_0       = out_q;
    assign data_out_0_last  = last_q;
    assign data_out_0_valid = valid_q;

    // Window slot currently being emitted, compared against the stored argmax.
    assign target = 32'(m_q) * 32'(KERNEL_WIDTH) + 32'(n_q);
    assign match  = (32'(line_q[j_q].index) == target);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_LOAD;
            load_col_q <= '0;
            j_q        <= '0;
            m_q        <= '0;
            n_q        <= '0;
            prow_q     <= '0;
            out_q      <= '0;
            last_q     <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            load_col_q <= load_col_d;
            j_q        <= j_d;
            m_q        <= m_d;
            n_q        <= n_d;
            prow_q     <= prow_d;
            out_q      <= out_d;
            last_q     <= last_d;
            valid_q    <= valid_d;
        end
    end

    // NOTE: the line buffer has no reset; every entry is rewritten in LOAD before EMIT reads it.
    always_ff @(posedge clk) begin
        if (accept) begin
            line_q[load_col_q] <= '{value: data_in_0, index: index_in_0};
        end
    end

    // NOTE: every variable gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        load_col_d = load_col_q;
        j_d        = j_q;
        m_d        = m_q;
        n_d        = n_q;
        prow_d     = prow_q;
        out_d      = out_q;
        last_d     = last_q;
        valid_d    = valid_q;
        accept     = 1'b0;

        case (state_q)
            S_LOAD: begin
                if (valid_q && data_out_0_ready) begin
                    valid_d = 1'b0;
                end
                if (data_in_0_valid) begin
                    accept = 1'b1;
                    if (load_col_q == COL_MAX) begin
                        load_col_d = '0;
                        state_d    = S_EMIT;
                    end else begin
                        load_col_d = load_col_q + 1'b1;
                    end
                end
            end
            S_EMIT: begin
                // A held element blocks the register until the consumer takes it.
                if (!valid_q || data_out_0_ready) begin
                    out_d   = match ? line_q[j_q].value : '0;
                    last_d  = (m_q == M_MAX) && (j_q == COL_MAX) &&
                              (n_q == N_MAX) && (prow_q == PROW_MAX);
                    valid_d = 1'b1;
                    if (n_q == N_MAX) begin
                        n_d = '0;
                        if (j_q == COL_MAX) begin
                            j_d = '0;
                            if (m_q == M_MAX) begin
                                m_d     = '0;
                                state_d = S_LOAD;
                                prow_d  = (prow_q == PROW_MAX) ? '0 : prow_q + 1'b1;
                            end else begin
                                m_d = m_q + 1'b1;
                            end
                        end else begin
                            j_d = j_q + 1'b1;
                        end
                    end else begin
                        n_d = n_q + 1'b1;
                    end
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

endmodule

// File: tb/tb_max_unpool2d.sv
// Directed scoreboard bench for max_unpool2d: a 2x2-kernel 2x2 map instance and a
// 3x1-kernel single-window instance for out-of-range index handling.
module tb_max_unpool2d;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 2x2 kernel, 2x2 pooled map
    logic [7:0] d_in;
    logic [1:0] i_in;
    logic       v_in;
    logic       r_in;
    logic [7:0] d_out;
    logic       l_out;
    logic       v_out;
    logic       r_out;

    // 3-wide, 1-high kernel, 1x1 pooled map
    logic [7:0] d2_in;
    logic [1:0] i2_in;
    logic       v2_in;
    logic       r2_in;
    logic [7:0] d2_out;
    logic       l2_out;
    logic       v2_out;
    logic       r2_out;

    beat_t exp_q[$];
    beat_t exp2_q[$];
    int    checks = 0;
    int    errors = 0;

    max_unpool2d dut (
        .clk              (clk),
        .rst              (rst),
        .data_in_0        (d_in),
        .index_in_0       (i_in),
        .data_in_0_valid  (v_in),
        .data_in_0_ready  (r_in),
        .data_out_0       (d_out),
        .data_out_0_last  (l_out),
        .data_out_0_valid (v_out),
        .data_out_0_ready (r_out)
    );

    max_unpool2d #(
        .DATA_IN_0_WIDTH  (1),
        .DATA_IN_0_HEIGHT (1),
        .KERNEL_WIDTH     (3),
        .KERNEL_HEIGHT    (1),
        .DATA_OUT_0_WIDTH (3),
        .DATA_OUT_0_HEIGHT(1)
    ) dut2 (
        .clk              (clk),
        .rst              (rst),
        .data_in_0        (d2_in),
        .index_in_0       (i2_in),
        .data_in_0_valid  (v2_in),
        .data_in_0_ready  (r2_in),
        .data_out_0       (d2_out),
        .data_out_0_last  (l2_out),
        .data_out_0_valid (v2_out),
        .data_out_0_ready (r2_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference model for one pooled row of the 2x2 instance.
    task automatic push_row(input logic [7:0] v0, input logic [1:0] i0,
                            input logic [7:0] v1, input logic [1:0] i1,
                            input bit last_row);
        for (int m = 0; m < 2; m++) begin
            for (int j = 0; j < 2; j++) begin
                for (int n = 0; n < 2; n++) begin
                    beat_t    b;
                    logic [7:0] v;
                    int       ix;
                    v  = (j == 0) ? v0 : v1;
                    ix = (j == 0) ? int'(i0) : int'(i1);
                    b.data = (ix == m * 2 + n) ? v : 8'h00;
                    b.last = last_row && (m == 1) && (j == 1) && (n == 1);
                    exp_q.push_back(b);
                end
            end
        end
    endtask

    task automatic send_elem(input logic [7:0] v, input logic [1:0] ix);
        int k;
        @(posedge clk); #1;
        d_in = v; i_in = ix; v_in = 1'b1;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (r_in) break;
        end
        if (k == 200) check("in_ready_timeout", 32'(r_in), 32'd1);
        @(posedge clk); #1;
        v_in = 1'b0;
    endtask

    task automatic send_row(input logic [7:0] v0, input logic [1:0] i0,
                            input logic [7:0] v1, input logic [1:0] i1,
                            input bit last_row, input int gap);
        push_row(v0, i0, v1, i1, last_row);
        send_elem(v0, i0);
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            check("in_ready_gap", 32'(r_in), 32'd1);
            @(posedge clk); #1;
        end
        send_elem(v1, i1);
    endtask

    // mode 0: constant ready; mode 1: ready 1,0,0 repeating.
    task automatic drain(input int n, input int mode);
        int    got  = 0;
        int    cyc  = 0;
        bit    held = 1'b0;
        beat_t hb;
        beat_t e;
        while (got < n && cyc < 1000) begin
            @(posedge clk); #1;
            r_out = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
            @(negedge clk);
            if (held && v_out) begin
                check("stall_data", 32'(d_out), 32'(hb.data));
                check("stall_last", 32'(l_out), 32'(hb.last));
            end
            held = 1'b0;
            if (v_out) begin
                if (r_out) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $error("FAIL extra_beat: observed %0h expected none", d_out);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_data", 32'(d_out), 32'(e.data));
                        check("out_last", 32'(l_out), 32'(e.last));
                    end
                    got++;
                end else begin
                    held    = 1'b1;
                    hb.data = d_out;
                    hb.last = l_out;
                end
            end
            cyc++;
        end
        if (got < n) check("drain_timeout", 32'(got), 32'(n));
        @(posedge clk); #1;
        r_out = 1'b1;
    endtask

    task automatic idle_check();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("idle_valid", 32'(v_out), 32'd0);
        end
    endtask

    task automatic send2(input logic [7:0] v, input logic [1:0] ix);
        int    k;
        int    got = 0;
        beat_t b;
        for (int n = 0; n < 3; n++) begin
            b.data = (int'(ix) == n) ? v : 8'h00;
            b.last = (n == 2);
            exp2_q.push_back(b);
        end
        @(posedge clk); #1;
        d2_in = v; i2_in = ix; v2_in = 1'b1;
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (r2_in) break;
        end
        if (k == 50) check("in2_ready_timeout", 32'(r2_in), 32'd1);
        @(posedge clk); #1;
        v2_in = 1'b0;
        for (k = 0; k < 50 && got < 3; k++) begin
            @(negedge clk);
            if (v2_out) begin
                b = exp2_q.pop_front();
                check("out2_data", 32'(d2_out), 32'(b.data));
                check("out2_last", 32'(l2_out), 32'(b.last));
                got++;
            end
        end
        if (got < 3) check("drain2_timeout", 32'(got), 32'd3);
    endtask

    initial begin
        rst   = 1'b1;
        d_in  = '0; i_in  = '0; v_in  = 1'b0; r_out  = 1'b1;
        d2_in = '0; i2_in = '0; v2_in = 1'b0; r2_out = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_data",   32'(d_out), 32'd0);
        check("rst_valid",  32'(v_out), 32'd0);
        check("rst_last",   32'(l_out), 32'd0);
        check("rst_ready",  32'(r_in),  32'd1);
        check("rst2_valid", 32'(v2_out), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic frame, constant ready
        send_row(8'd5, 2'd0, 8'd7, 2'd3, 1'b0, 0);
        drain(8, 0);
        send_row(8'd9, 2'd1, 8'd3, 2'd2, 1'b1, 0);
        drain(8, 0);
        idle_check();

        // Same frame under backpressure; the second row loads while output may stall
        fork
            begin
                send_row(8'd5, 2'd0, 8'd7, 2'd3, 1'b0, 0);
                send_row(8'd9, 2'd1, 8'd3, 2'd2, 1'b1, 0);
            end
            drain(16, 1);
        join
        idle_check();

        // Input gaps, negative value passed through as raw bits
        send_row(8'h80, 2'd0, 8'h01, 2'd3, 1'b0, 3);
        drain(8, 0);
        send_row(8'h02, 2'd2, 8'h44, 2'd1, 1'b1, 2);
        drain(8, 0);
        idle_check();

        // Reset during the second row's emission, then a fresh frame
        send_row(8'd5, 2'd0, 8'd7, 2'd3, 1'b0, 0);
        drain(8, 0);
        send_row(8'd9, 2'd1, 8'd3, 2'd2, 1'b1, 0);
        drain(3, 0);
        r_out = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_valid", 32'(v_out), 32'd0);
        check("midrst_ready", 32'(r_in),  32'd1);
        check("midrst_last",  32'(l_out), 32'd0);
        exp_q.delete();
        r_out = 1'b1;
        send_row(8'h11, 2'd3, 8'h22, 2'd0, 1'b0, 0);
        drain(8, 0);
        send_row(8'h33, 2'd2, 8'h44, 2'd1, 1'b1, 0);
        drain(8, 0);
        idle_check();

        // Out-of-range index on the 3-slot kernel, then in-range slots
        send2(8'h7F, 2'd3);
        send2(8'h12, 2'd1);
        send2(8'h80, 2'd0);

        check("queue_empty",  32'(exp_q.size()),  32'd0);
        check("queue2_empty", 32'(exp2_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
